// File: rtl/steel_ram_arbiter_if.sv
// Per-master request/response bundle for the Steel RAM arbiter.
// The master modport is the requester side, the slave modport is the arbiter side.
`timescale 1ns/1ps
interface steel_ram_arbiter_if;
    logic        REQ;
    logic [31:0] ADDR;
    logic        WR;
    logic [3:0]  MASK;
    logic [31:0] WDATA;
    logic        GNT;
    logic        RVALID;
    logic [31:0] RDATA;
    logic        ERR;

    modport master (
        output REQ,
        output ADDR,
        output WR,
        output MASK,
        output WDATA,
        input  GNT,
        input  RVALID,
        input  RDATA,
        input  ERR
    );

    modport slave (
        input  REQ,
        input  ADDR,
        input  WR,
        input  MASK,
        input  WDATA,
        output GNT,
        output RVALID,
        output RDATA,
        output ERR
    );
endinterface

// File: rtl/steel_ram_arbiter.sv
// Round-robin arbiter letting two masters share one single-port byte-masked RAM.
// Grants are combinational; read data and error pulses return one cycle later to the owner.
`timescale 1ns/1ps
module steel_ram_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RESET,
    steel_ram_arbiter_if.slave    m0,
    steel_ram_arbiter_if.slave    m1,
    output logic                  RAM_EN,
    output logic [3:0]            RAM_WE,
    output logic [ADDR_WIDTH-3:0] RAM_ADDR,
    output logic [31:0]           RAM_WDATA,
    input  logic [31:0]           RAM_RDATA
);
    logic        last_gnt;
    logic        pend_valid;
    logic        pend_owner;
    logic        pend_err;
    logic        pend_read;
    logic        m0_rvalid_q;
    logic        m1_rvalid_q;
    logic        m0_err_q;
    logic        m1_err_q;

    logic        req0;
    logic        req1;
    logic        gnt0;
    logic        gnt1;
    logic        granted;
    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_wr;
    logic [3:0]  sel_mask;
    logic        in_range;
    logic        unused_addr_bits;

    // Requests are masked while reset is high so nothing reaches the RAM.
    assign req0 = m0.REQ & ~RESET;
    assign req1 = m1.REQ & ~RESET;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = ~last_gnt;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign granted = gnt0 | gnt1;
    assign sel     = gnt1;

    always_comb begin
        sel_addr  = m0.ADDR;
        sel_wdata = m0.WDATA;
        sel_wr    = m0.WR;
        sel_mask  = m0.MASK;
        if (sel) begin
            sel_addr  = m1.ADDR;
            sel_wdata = m1.WDATA;
            sel_wr    = m1.WR;
            sel_mask  = m1.MASK;
        end
    end

    assign in_range         = (sel_addr[31:ADDR_WIDTH] == '0);
    assign unused_addr_bits = ^sel_addr[1:0];

    // Out-of-range accesses are granted but never touch the array.
    always_comb begin
        RAM_EN    = granted & in_range;
        RAM_WE    = 4'b0000;
        RAM_ADDR  = '0;
        RAM_WDATA = 32'h0;
        if (granted && in_range) begin
            RAM_ADDR = sel_addr[ADDR_WIDTH-1:2];
            if (sel_wr) begin
                RAM_WE = sel_mask;
            end
        end
        if (granted && sel_wr) begin
            RAM_WDATA = sel_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_gnt    <= 1'b1;
            pend_valid  <= 1'b0;
            pend_owner  <= 1'b0;
            pend_err    <= 1'b0;
            pend_read   <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            if (granted) begin
                last_gnt <= sel;
            end
            pend_valid  <= granted;
            pend_owner  <= sel;
            pend_err    <= ~in_range;
            pend_read   <= ~sel_wr;
            m0_rvalid_q <= gnt0 & ~sel_wr;
            m1_rvalid_q <= gnt1 & ~sel_wr;
            m0_err_q    <= gnt0 & ~in_range;
            m1_err_q    <= gnt1 & ~in_range;
        end
    end

    // Read data is steered by the pending owner, independent of this cycle's grant.
    assign m0.GNT    = gnt0;
    assign m1.GNT    = gnt1;
    assign m0.RVALID = m0_rvalid_q;
    assign m1.RVALID = m1_rvalid_q;
    assign m0.ERR    = m0_err_q;
    assign m1.ERR    = m1_err_q;
    assign m0.RDATA  = (pend_valid && !pend_owner && pend_read && !pend_err) ? RAM_RDATA : 32'h0;
    assign m1.RDATA  = (pend_valid &&  pend_owner && pend_read && !pend_err) ? RAM_RDATA : 32'h0;
endmodule

// File: tb/tb_steel_ram_arbiter.sv
// Bench for steel_ram_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of arbitration and memory.
`timescale 1ns/1ps
module tb_steel_ram_arbiter;
    localparam int AW    = 12;
    localparam int WORDS = 1 << (AW - 2);

    logic          CLK;
    logic          RESET;
    logic          RAM_EN;
    logic [3:0]    RAM_WE;
    logic [AW-3:0] RAM_ADDR;
    logic [31:0]   RAM_WDATA;
    logic [31:0]   RAM_RDATA;

    steel_ram_arbiter_if m0_if ();
    steel_ram_arbiter_if m1_if ();

    steel_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .m0        (m0_if),
        .m1        (m1_if),
        .RAM_EN    (RAM_EN),
        .RAM_WE    (RAM_WE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_WDATA (RAM_WDATA),
        .RAM_RDATA (RAM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural single-port RAM macro with one-cycle read latency.
    logic [31:0] ram [0:WORDS-1];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE == 4'b0000) begin
                RAM_RDATA <= ram[RAM_ADDR];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (RAM_WE[b]) ram[RAM_ADDR][8*b +: 8] = RAM_WDATA[8*b +: 8];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state: who won last, the outstanding response and the memory image.
    int          last_win;
    bit          pend_v;
    int          pend_owner;
    bit          pend_rd;
    bit          pend_err;
    logic [31:0] pend_data;
    logic [31:0] model_mem [0:WORDS-1];

    logic        snap_gnt0, snap_gnt1, snap_en, snap_rv0, snap_rv1, snap_err0, snap_err1;
    logic [3:0]  snap_we;
    logic [31:0] snap_addr, snap_wdata, snap_rd0, snap_rd1;
    int          gnt_who;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input bit req, input logic [31:0] addr,
                                 input bit wr, input logic [3:0] mask, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.REQ = req; m0_if.ADDR = addr; m0_if.WR = wr; m0_if.MASK = mask; m0_if.WDATA = wdata;
        end else begin
            m1_if.REQ = req; m1_if.ADDR = addr; m1_if.WR = wr; m1_if.MASK = mask; m1_if.WDATA = wdata;
        end
    endtask

    task automatic preloadWord(input int idx, input logic [31:0] val);
        ram[idx]       = val;
        model_mem[idx] = val;
    endtask

    task automatic modelReset();
        last_win = 1;
        pend_v   = 1'b0;
    endtask

    // One bus cycle: sample at the falling edge, compare with the model, advance the model.
    task automatic stepCycle();
        int          exp_who;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  mk;
        bit          w;
        bit          inr;
        bit          exp_en;
        bit          exp_rv;
        bit          exp_er;
        bit          owner;
        logic [31:0] rd_obs;
        @(negedge CLK);
        snap_gnt0 = m0_if.GNT;   snap_gnt1 = m1_if.GNT;
        snap_en   = RAM_EN;      snap_we   = RAM_WE;
        snap_addr = 32'(RAM_ADDR); snap_wdata = RAM_WDATA;
        snap_rv0  = m0_if.RVALID; snap_rv1 = m1_if.RVALID;
        snap_err0 = m0_if.ERR;   snap_err1 = m1_if.ERR;
        snap_rd0  = m0_if.RDATA; snap_rd1  = m1_if.RDATA;
        gnt_who   = (snap_gnt0 && snap_gnt1) ? 3 : snap_gnt0 ? 0 : snap_gnt1 ? 1 : -1;

        if (m0_if.REQ && m1_if.REQ) exp_who = (last_win == 0) ? 1 : 0;
        else if (m0_if.REQ)         exp_who = 0;
        else if (m1_if.REQ)         exp_who = 1;
        else                        exp_who = -1;

        a = 32'h0; wd = 32'h0; mk = 4'h0; w = 1'b0;
        if (exp_who == 0) begin a = m0_if.ADDR; wd = m0_if.WDATA; mk = m0_if.MASK; w = m0_if.WR; end
        if (exp_who == 1) begin a = m1_if.ADDR; wd = m1_if.WDATA; mk = m1_if.MASK; w = m1_if.WR; end
        inr    = (a[31:AW] == '0);
        exp_en = (exp_who >= 0) && inr;

        checkOutput("gnt0", 32'(snap_gnt0), 32'(exp_who == 0));
        checkOutput("gnt1", 32'(snap_gnt1), 32'(exp_who == 1));
        checkOutput("ram_en", 32'(snap_en), 32'(exp_en));
        checkOutput("ram_we", 32'(snap_we), (exp_en && w) ? 32'(mk) : 32'h0);
        if (exp_en) checkOutput("ram_addr", snap_addr, 32'(a[AW-1:2]));
        if (exp_en && w) checkOutput("ram_wdata", snap_wdata, wd);
        if (exp_who < 0) begin
            checkOutput("idle_addr", snap_addr, 32'h0);
            checkOutput("idle_wdata", snap_wdata, 32'h0);
        end

        for (int x = 0; x < 2; x++) begin
            owner  = pend_v && (pend_owner == x);
            exp_rv = owner && pend_rd;
            exp_er = owner && pend_err;
            rd_obs = (x == 0) ? snap_rd0 : snap_rd1;
            checkOutput($sformatf("rvalid%0d", x), 32'((x == 0) ? snap_rv0 : snap_rv1), 32'(exp_rv));
            checkOutput($sformatf("err%0d", x), 32'((x == 0) ? snap_err0 : snap_err1), 32'(exp_er));
            if (exp_rv || !owner) checkOutput($sformatf("rdata%0d", x), rd_obs, exp_rv ? pend_data : 32'h0);
        end

        if (exp_who >= 0) begin
            last_win   = exp_who;
            pend_v     = 1'b1;
            pend_owner = exp_who;
            pend_rd    = !w;
            pend_err   = !inr;
            pend_data  = (inr && !pend_err) ? model_mem[a[AW-1:2]] : 32'h0;
            if (inr && w) begin
                for (int b = 0; b < 4; b++) begin
                    if (mk[b]) model_mem[a[AW-1:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end else begin
            pend_v = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    bit hold0, hold1;
    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        RESET = 1'b1;
        applyStimulus(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < WORDS; i++) preloadWord(i, 32'h0);
        for (int i = 0; i < 32; i++) preloadWord(i, $urandom);
        modelReset();
        $display("[TB] reset checks");
        #12;
        checkOutput("rst_gnt0", 32'(m0_if.GNT), 32'h0);
        checkOutput("rst_gnt1", 32'(m1_if.GNT), 32'h0);
        checkOutput("rst_ram_en", 32'(RAM_EN), 32'h0);
        checkOutput("rst_ram_we", 32'(RAM_WE), 32'h0);
        checkOutput("rst_rvalid0", 32'(m0_if.RVALID), 32'h0);
        checkOutput("rst_err1", 32'(m1_if.ERR), 32'h0);
        checkOutput("rst_rdata0", m0_if.RDATA, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        $display("[TB] contention");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1'b1, 32'(i) << 2, 1'b0, 4'h0, 32'h0);
            applyStimulus(1, 1'b1, (32'(i) << 2) + 32'h40, 1'b0, 4'h0, 32'h0);
            stepCycle();
            checkOutput($sformatf("seq%0d", i), 32'(gnt_who), 32'(exp_seq[i]));
        end
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();

        $display("[TB] single read");
        preloadWord(5, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 32'h14, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("sr_gnt0", 32'(snap_gnt0), 32'h1);
        checkOutput("sr_en", 32'(snap_en), 32'h1);
        checkOutput("sr_addr", snap_addr, 32'h5);
        checkOutput("sr_we", 32'(snap_we), 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("sr_rv0", 32'(snap_rv0), 32'h1);
        checkOutput("sr_rd0", snap_rd0, 32'hDEADBEEF);
        checkOutput("sr_m1", {snap_rd1[29:0], snap_rv1, snap_err1}, 32'h0);

        $display("[TB] masked write");
        preloadWord(8, 32'h0);
        applyStimulus(1, 1'b1, 32'h20, 1'b1, 4'b0101, 32'h11223344);
        stepCycle();
        checkOutput("mw_gnt1", 32'(snap_gnt1), 32'h1);
        checkOutput("mw_we", 32'(snap_we), 32'h5);
        checkOutput("mw_addr", snap_addr, 32'h8);
        applyStimulus(1, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("mw_no_resp", {30'h0, snap_rv1, snap_err1}, 32'h0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("mw_rd1", snap_rd1, 32'h00220044);

        $display("[TB] out of range");
        applyStimulus(0, 1'b1, 32'h00001000, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("oor_gnt0", 32'(snap_gnt0), 32'h1);
        checkOutput("oor_en", 32'(snap_en), 32'h0);
        applyStimulus(0, 1'b1, 32'h00001000, 1'b1, 4'hF, 32'h12345678);
        stepCycle();
        checkOutput("oor_rd_resp", {snap_rd0[29:0], snap_rv0, snap_err0}, 32'h3);
        checkOutput("oor_wr_en", 32'(snap_en), 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("oor_wr_resp", {30'h0, snap_rv0, snap_err0}, 32'h1);

        $display("[TB] back to back");
        applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'hF, 32'hA5A5A5A5);
        stepCycle();
        checkOutput("b2b_gnt_a", 32'(snap_gnt0), 32'h1);
        applyStimulus(0, 1'b1, 32'h40, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("b2b_gnt_b", 32'(snap_gnt0), 32'h1);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("b2b_rv0", 32'(snap_rv0), 32'h1);
        checkOutput("b2b_rd0", snap_rd0, 32'hA5A5A5A5);

        $display("[TB] reset mid-access");
        applyStimulus(1, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("rm_gnt1", 32'(snap_gnt1), 32'h1);
        RESET = 1'b1;
        applyStimulus(0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("rm_rv1", 32'(m1_if.RVALID), 32'h0);
        checkOutput("rm_hold_gnt", {30'h0, m0_if.GNT, m1_if.GNT}, 32'h0);
        checkOutput("rm_hold_en", 32'(RAM_EN), 32'h0);
        #1;
        RESET = 1'b0;
        modelReset();
        stepCycle();
        checkOutput("rm_first_gnt", 32'(gnt_who), 32'h0);
        checkOutput("rm_rv1_after", 32'(snap_rv1), 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();

        $display("[TB] random traffic");
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                logic [31:0] ra;
                bit          held;
                held = (m == 0) ? hold0 : hold1;
                if (!held) begin
                    if ($urandom_range(0, 99) < 60) begin
                        ra = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
                        if ($urandom_range(0, 9) == 0) ra = ra | (32'($urandom_range(1, 1048575)) << AW);
                        applyStimulus(m, 1'b1, ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
                        if (m == 0) hold0 = 1'b1; else hold1 = 1'b1;
                    end else begin
                        applyStimulus(m, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
                    end
                end
            end
            stepCycle();
            if (snap_gnt0) hold0 = 1'b0;
            if (snap_gnt1) hold1 = 1'b0;
        end
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
